alu_writeback_unit: RTL
=======================

Name: alu_writeback_unit

Overview:
Consumer end of the ALU result interface. Captures the ALU outputs (OpCode, RdOut, AluResult, branchResult) into a one-entry pipeline register and retires them. Retiring means either a register-file write (data ops) or branch resolution (B/BEG), with a PC redirect and a fixed-length flush of the front end. Sits between the ALU and the register file / fetch unit and supplies a forwarding path back to operand select.

Parameters:
DATA_W, 32, result/write data width
ADDR_W, 7, register/branch-target width (matches Rd and branchResult)
FLUSH_CYCLES, 2, cycles flush is held after a taken branch (1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
ex_valid  in  1  ALU result present this cycle
ex_ready  out  1  unit accepts ALU result this cycle
ex_opcode  in  5  ALU OpCode output
ex_rd  in  ADDR_W  ALU RdOut
ex_branch  in  ADDR_W  ALU branchResult (branch target)
ex_result  in  DATA_W  ALU AluResult
rf_we  out  1  register-file write request
rf_waddr  out  ADDR_W  write address
rf_wdata  out  DATA_W  write data
rf_ready  in  1  register file accepts write this cycle
fwd_valid  out  1  stage holds a pending write (forwarding valid)
fwd_rd  out  ADDR_W  forwarded destination
fwd_data  out  DATA_W  forwarded value
pc_load  out  1  one-cycle redirect pulse
pc_target  out  ADDR_W  redirect target
flush  out  1  squash younger front-end instructions
illegal  out  1  sticky: unknown opcode retired

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high. On reset: stage empty, state RUN, every output 0 (ex_ready becomes 1 the cycle after rst deasserts).
- Opcode classes: WRITE = 1,2,3,4,5,6,9,10. BRANCH = 7 (unconditional, target ex_branch). BEG = 8 (taken iff ex_result[0]==1, target ex_branch). NOP = 0. 11..31 = illegal: retired as NOP and set illegal; illegal clears only on rst.
- FSM states:
  - RUN: normal operation.
  - FLUSH: counter loaded with FLUSH_CYCLES, decrements each cycle; returns to RUN when the counter reaches 1.
- Capture: a transfer occurs when ex_valid && ex_ready. ex_ready = (state==RUN) && (stage empty || stage retiring this cycle). This gives a back-to-back throughput of 1 per cycle when rf_ready=1.
- Retire, one cycle after capture at the earliest:
  - WRITE: rf_we=1 with rf_waddr/rf_wdata held stable until rf_ready=1. The stage empties on rf_we && rf_ready.
  - NOP, illegal, or not-taken BEG: empties the cycle after capture, with no outputs.
  - Taken branch: pc_load=1 for exactly one cycle with pc_target=captured target. The stage empties the same cycle, state goes to FLUSH, and flush=1 from that cycle for FLUSH_CYCLES cycles total. ex_ready=0 while flush=1.
- Forwarding: fwd_valid=1 while the stage holds an unretired WRITE. fwd_rd/fwd_data mirror the stage and are 0 when fwd_valid=0.
- Rd=0 is an ordinary register; writes to it are performed.
- ex_valid while ex_ready=0: the producer must hold; inputs are ignored and no capture occurs.
- ex_valid during FLUSH: ignored (not captured, not counted).
- rst mid-write or mid-flush: everything is discarded, and pc_load/flush drop in the next cycle.
- A taken branch never overlaps a pending write, because the stage holds one entry.

Optional Feature:
Macro WB_PERF_EN.
- Defined: adds outputs perf_retired[31:0] (increments on every retire, including NOP and illegal) and perf_taken[31:0] (increments on each pc_load). Both wrap at 2^32, reset to 0 on rst, and count 1 per cycle max.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_valid=1 -> all outputs 0, no capture. One cycle after rst falls, ex_ready=1.
- Back-to-back writes: sum (op 5, rd=3, result=0x0000000A) then mlt (op 2, rd=4, result=0x14) with rf_ready=1 -> rf_we asserted 2 consecutive cycles, writing 3<-0xA then 4<-0x14. fwd_valid tracks each.
- Backpressure: WRITE op 1, rd=7, result=0xDEADBEEF with rf_ready=0 for 3 cycles -> rf_we/addr/data stable for 4 cycles and ex_ready=0 for 3 of them. Retires when rf_ready=1; fwd_data=0xDEADBEEF throughout.
- Branch: B (op 7, branch=0x25), FLUSH_CYCLES=2 -> pc_load=1 and pc_target=0x25 for exactly 1 cycle, flush=1 for 2 cycles, ex_ready=0 for 2 cycles. An ex_valid presented during flush is not captured.
- BEG: op 8, result=0, branch=0x10 -> no pc_load, no flush. Repeat with result=1 -> pc_load and pc_target=0x10.
- Illegal plus perf counters (WB_PERF_EN): op 13, then op 0 -> illegal=1 sticky, no rf_we, perf_retired=2, perf_taken=0.

Source files
------------

// File: rtl/alu_writeback_unit.sv
// -----------------------------------------------------------------------------
// alu_writeback_unit
//
// Consumer end of the ALU result interface. Captures one ALU result into a
// single-entry stage and retires it either as a register-file write (data
// ops) or as a branch resolution (PC redirect plus a fixed-length front-end
// flush). Also provides a forwarding view of the pending write.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   ex_valid/ready   ALU result handshake
//   ex_opcode/rd/branch/result   captured ALU outputs
//   rf_we/waddr/wdata, rf_ready  register-file write, held until rf_ready
//   fwd_valid/rd/data            pending-write forwarding path
//   pc_load/pc_target            one-cycle redirect on a taken branch
//   flush                        squash younger front-end instructions
//   illegal                      sticky, set when an unknown opcode retires
//
// Optional build macro WB_PERF_EN adds perf_retired / perf_taken counters.
// -----------------------------------------------------------------------------
module alu_writeback_unit #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 7,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [4:0]        ex_opcode,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [ADDR_W-1:0] ex_branch,
  input  logic [DATA_W-1:0] ex_result,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush,
  output logic              illegal
`ifdef WB_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_taken
`endif
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;
  typedef enum logic [1:0] {K_NONE, K_WRITE, K_TAKEN} kind_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              stg_valid_q, stg_valid_d;
  kind_e             stg_kind_q, stg_kind_d;
  logic              stg_ill_q, stg_ill_d;
  logic [ADDR_W-1:0] stg_rd_q, stg_rd_d;
  logic [DATA_W-1:0] stg_data_q, stg_data_d;
  logic [ADDR_W-1:0] stg_tgt_q, stg_tgt_d;
  logic              illegal_q, illegal_d;

  kind_e in_kind;
  logic  in_ill;
  logic  do_write, do_branch, retire, capture;

  // Branch outcome is resolved at capture so the stage only stores the class.
  always_comb begin
    in_kind = K_NONE;
    in_ill  = 1'b0;
    case (ex_opcode)
      5'd1, 5'd2, 5'd3, 5'd4,
      5'd5, 5'd6, 5'd9, 5'd10: in_kind = K_WRITE;
      5'd7:                    in_kind = K_TAKEN;
      5'd8:                    in_kind = ex_result[0] ? K_TAKEN : K_NONE;
      5'd0:                    in_kind = K_NONE;
      default:                 in_ill  = 1'b1;
    endcase
  end

  assign do_write  = stg_valid_q && (stg_kind_q == K_WRITE);
  assign do_branch = stg_valid_q && (stg_kind_q == K_TAKEN);
  assign retire    = stg_valid_q && ((stg_kind_q != K_WRITE) || rf_ready);
  // The redirect cycle already counts as the first flush cycle, so no
  // capture is allowed in it even though the FSM is still in RUN.
  assign ex_ready  = !rst && (state_q == ST_RUN) && !do_branch &&
                     (!stg_valid_q || retire);
  assign capture   = ex_valid && ex_ready;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. FLUSH covers the flush cycles after the redirect cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (do_branch && (FLUSH_CYCLES > 1)) begin
          state_d = ST_FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    pc_load   = do_branch;
    pc_target = do_branch ? stg_tgt_q : '0;
    flush     = do_branch || (state_q == ST_FLUSH);
  end

  // Stage next-state
  always_comb begin
    stg_valid_d = stg_valid_q;
    stg_kind_d  = stg_kind_q;
    stg_ill_d   = stg_ill_q;
    stg_rd_d    = stg_rd_q;
    stg_data_d  = stg_data_q;
    stg_tgt_d   = stg_tgt_q;
    illegal_d   = illegal_q | (retire && stg_ill_q);
    if (retire) stg_valid_d = 1'b0;
    if (capture) begin
      stg_valid_d = 1'b1;
      stg_kind_d  = in_kind;
      stg_ill_d   = in_ill;
      stg_rd_d    = ex_rd;
      stg_data_d  = ex_result;
      stg_tgt_d   = ex_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid_q <= 1'b0;
      stg_kind_q  <= K_NONE;
      stg_ill_q   <= 1'b0;
      stg_rd_q    <= '0;
      stg_data_q  <= '0;
      stg_tgt_q   <= '0;
      illegal_q   <= 1'b0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_kind_q  <= stg_kind_d;
      stg_ill_q   <= stg_ill_d;
      stg_rd_q    <= stg_rd_d;
      stg_data_q  <= stg_data_d;
      stg_tgt_q   <= stg_tgt_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    rf_we     = do_write;
    rf_waddr  = do_write ? stg_rd_q   : '0;
    rf_wdata  = do_write ? stg_data_q : '0;
    fwd_valid = do_write;
    fwd_rd    = do_write ? stg_rd_q   : '0;
    fwd_data  = do_write ? stg_data_q : '0;
    illegal   = illegal_q;
  end

`ifdef WB_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_taken_q, perf_taken_d;

  always_comb begin
    perf_retired_d = perf_retired_q + {31'd0, retire};
    perf_taken_d   = perf_taken_q + {31'd0, do_branch};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_taken_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_taken_q   <= perf_taken_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_taken   = perf_taken_q;
`endif

endmodule
